// File: rtl/approx_mult_datapath_if.sv
// Control/data bundle between the approximate-multiplier controller and its datapath.
// The controller drives operands and per-cycle control levels; the datapath
// returns its normalisation/counter status flags and the scaled product.
interface approx_mult_datapath_if;
   logic [15:0] A_in;
   logic [15:0] B_in;
   logic        loadA;
   logic        loadB;
   logic        shlA;
   logic        shlB;
   logic        rst5;
   logic        cntU;
   logic        cntD;
   logic        loadOut;
   logic        shrOut;
   logic        DoneA;
   logic        DoneB;
   logic        downDone;
   logic [31:0] result;

   modport master (
      output A_in, B_in, loadA, loadB, shlA, shlB, rst5, cntU, cntD, loadOut, shrOut,
      input  DoneA, DoneB, downDone, result
   );

   modport slave (
      input  A_in, B_in, loadA, loadB, shlA, shlB, rst5, cntU, cntD, loadOut, shrOut,
      output DoneA, DoneB, downDone, result
   );
endinterface

// File: rtl/approx_mult_datapath.sv
// Approximate 16x16 multiplier datapath: both operands are left-normalised,
// their top bytes are multiplied, and the product is shifted back right by the
// total normalisation count. Pure datapath: every control input is a level
// sampled on each clk edge; sequencing lives in the external controller.

// One operand register with load / shift-left and a "normalised" flag.
module opndReg #(
   parameter int OP_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [OP_W-1:0] din,
   input  logic            load,
   input  logic            shl,
   output logic [OP_W-1:0] q,
   output logic            done
);
   // Load wins over shift; shift fills with zero.
   always_ff @(posedge clk) begin
      if (rst)       q <= '0;
      else if (load) q <= din;
      else if (shl)  q <= {q[OP_W-2:0], 1'b0};
   end

   // A zero operand counts as normalised so it never requests shifts.
   assign done = q[OP_W-1] | (q == '0);
endmodule

module approx_mult_datapath (
   input  logic                  clk,
   input  logic                  rst,
   approx_mult_datapath_if.slave bus
);
   localparam int OP_W   = 16;
   localparam int NUM_OP = 2;     // index 0 = A, 1 = B
   localparam int CNT_W  = 5;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NUM_OP-1:0][OP_W-1:0] opDin;
   logic [NUM_OP-1:0][OP_W-1:0] opQ;
   logic [NUM_OP-1:0]           opLoad;
   logic [NUM_OP-1:0]           opShl;
   logic [NUM_OP-1:0]           opDone;

   logic [CNT_W-1:0] cnt;
   logic [31:0]      outReg;
   logic [7:0]       aHi;
   logic [7:0]       bHi;
   logic [15:0]      prod;

   assign opDin  = {bus.B_in,  bus.A_in};
   assign opLoad = {bus.loadB, bus.loadA};
   assign opShl  = {bus.shlB,  bus.shlA};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_OP; gi++) begin : gOp
         opndReg #(.OP_W(OP_W)) uOp (
            .clk  (clk),
            .rst  (rst),
            .din  (opDin[gi]),
            .load (opLoad[gi]),
            .shl  (opShl[gi]),
            .q    (opQ[gi]),
            .done (opDone[gi])
         );
      end
   endgenerate

   // Shift counter: clear has priority, opposing steps cancel, saturates at both ends.
   always_ff @(posedge clk) begin
      if (rst || bus.rst5)
         cnt <= '0;
      else if (bus.cntU && !bus.cntD && cnt != CNT_MAX)
         cnt <= cnt + 1'b1;
      else if (bus.cntD && !bus.cntU && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   // Top bytes of the current operand registers feed the product with no extra stage.
   assign aHi  = opQ[0][OP_W-1 -: 8];
   assign bHi  = opQ[1][OP_W-1 -: 8];
   assign prod = {8'd0, aHi} * {8'd0, bHi};

   // Output register: load scaled product (wins over shift) or shift right filling 0.
   always_ff @(posedge clk) begin
      if (rst)              outReg <= '0;
      else if (bus.loadOut) outReg <= {prod, 16'h0000};
      else if (bus.shrOut)  outReg <= {1'b0, outReg[31:1]};
   end

   assign bus.DoneA    = opDone[0];
   assign bus.DoneB    = opDone[1];
   assign bus.downDone = (cnt == '0);
   assign bus.result   = outReg;
endmodule

// File: doc/approx_mult_datapath.md
APPROX_MULT_DATAPATH -- requirements
Module: approx_mult_datapath

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, synchronous, active-high reset; clock clk.
REQ-003 SHALL have port A_in, input, 16, operand A, unsigned.
REQ-004 SHALL have port B_in, input, 16, operand B, unsigned.
REQ-005 SHALL have ports loadA, loadB, input, 1 each, capture A_in or B_in into the A or B register.
REQ-006 SHALL have ports shlA, shlB, input, 1 each, shift the A or B register left by 1, filling 0.
REQ-007 SHALL have port rst5, input, 1, clear the 5-bit shift counter.
REQ-008 SHALL have ports cntU, cntD, input, 1 each, increment or decrement the shift counter.
REQ-009 SHALL have port loadOut, input, 1, capture the scaled product into the output register.
REQ-010 SHALL have port shrOut, input, 1, shift the output register right by 1, filling 0.
REQ-011 SHALL have ports DoneA, DoneB, output, 1 each, indicate the A or B register is normalised.
REQ-012 SHALL have port downDone, output, 1, indicate the shift counter equals 0.
REQ-013 SHALL have port result, output, 32, approximate A_in*B_in, equal to the output register.

Function
REQ-014 SHALL hold 16-bit registers A_reg and B_reg, a 5-bit counter cnt and a 32-bit register out_reg.
REQ-015 A_reg on each edge:
- loadA=1: load A_in.
- else shlA=1: load {A_reg[14:0],0}.
- else: hold.
- B_reg SHALL behave identically with loadB, shlB and B_in.
REQ-016 DoneA SHALL be combinational: A_reg[15] OR (A_reg==0). A zero operand therefore never requests shifts.
REQ-017 DoneB SHALL be combinational: B_reg[15] OR (B_reg==0).
REQ-018 cnt priority on each edge:
- rst5: load 0.
- else cntU XOR cntD: step up or down by 1.
- else: hold.
REQ-019 cntU and cntD asserted together SHALL leave cnt unchanged.
REQ-020 cnt SHALL saturate: increment at 31 holds 31; decrement at 0 holds 0. No wrap-around.
REQ-021 downDone SHALL be combinational: (cnt==0).
REQ-022 out_reg on each edge:
- loadOut=1: load {P,16'h0000}, where P = A_reg[15:8]*B_reg[15:8] as a full 16-bit unsigned product.
- else shrOut=1: load {0,out_reg[31:1]}.
- else: hold.
REQ-023 loadOut SHALL sample A_reg and B_reg as held in the same cycle; loading the product SHALL add no extra pipeline latency.
REQ-024 The intended sequence SHALL yield result = (Ahi*Bhi*2^16) >> (sA+sB), where sA and sB are the left-shift counts and Ahi, Bhi are the top bytes after normalisation.
REQ-025 Each shift cycle (shlA or shlB) SHALL coincide with one cntU; a control step of that kind adds exactly 1 to cnt.
REQ-026 Each shrOut cycle SHALL coincide with one cntD; downDone rises in the cycle after the final shift that brings cnt to 0.
REQ-027 A simultaneous loadOut and shrOut SHALL give priority to loadOut.
REQ-028 Control inputs SHALL be treated as level signals sampled every edge; no internal FSM or handshake beyond these registers.

Reset
REQ-029 rst=1 SHALL set A_reg, B_reg, cnt and out_reg to 0 on the next edge, overriding all control inputs.
- After reset: DoneA=1, DoneB=1, downDone=1, result=0.
REQ-030 rst asserted mid-operation (during any shift phase) SHALL abort it and give the same reset values; no partial state is retained.

Verification
REQ-031 A=0x0003, B=0x0005, full sequence -> 14 A shifts, 13 B shifts, cnt=27, P=0x7800, after 27 shrOut result=0x0000000F.
REQ-032 A=0x8000, B=0x8000 -> DoneA, DoneB high right after load, cnt=0, result=0x40000000 with no shrOut.
REQ-033 A=0x1234, B=0x00FF -> cnt=11, P=0x906F, final result=0x00120DE0.
REQ-034 A=0x0000, B=0x0005 -> DoneA immediately, cnt=13, P=0, result=0.
REQ-035 Counter edges -> 32 cntU from 0 gives cnt=31, no wrap; cntD at 0 keeps downDone=1; cntU and cntD together hold cnt; rst5 with cntU gives 0.
REQ-036 rst pulsed mid-B-shift with A=0x0003, B=0x0005 -> all registers 0, result=0, DoneA=DoneB=downDone=1 on the next cycle.
